// File: rtl/wb_ext_bridge_if.sv
// Wishbone slave and ext memory-port signals of the bridge, grouped into one bundle.
// slave = bridge view, master = the side driving Wishbone requests and answering ext requests.
interface wb_ext_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [SEL_W-1:0]  wbs_sel_i;
    logic [ADDR_W-1:0] wbs_adr_i;
    logic [DATA_W-1:0] wbs_dat_i;
    logic              wbs_ack_o;
    logic [DATA_W-1:0] wbs_dat_o;

    logic              ext_valid;
    logic [ADDR_W-1:0] ext_address;
    logic [DATA_W-1:0] ext_write_data;
    logic [SEL_W-1:0]  ext_write_strobe;
    logic              ext_ready;
    logic [DATA_W-1:0] ext_read_data;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output ext_valid, ext_address, ext_write_data, ext_write_strobe,
        input  ext_ready, ext_read_data
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  ext_valid, ext_address, ext_write_data, ext_write_strobe,
        output ext_ready, ext_read_data
    );
endinterface

// File: rtl/wb_ext_bridge.sv
// Wishbone-to-ext bridge, one transaction in flight: window ack 2+waits, CSR/miss ack 1 cycle.
// Backpressure: ext_valid held until ext_ready or watchdog expiry; errors get ERR_DATA and sticky flags.
module wb_ext_bridge #(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h3000_0000,
    parameter logic [ADDR_W-1:0]  ADDR_MASK = 32'hFFF0_0000,
    parameter logic [ADDR_W-1:0]  CSR_ADDR  = 32'h2FFF_FF00,
    parameter int                 TIMEOUT   = 255,
    parameter logic [DATA_W-1:0]  ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_ext_bridge_if.slave        bus,
    output logic                  err_irq
);
    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam bit               WDOG_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXT  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ext_valid_q, ext_valid_d;
    logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
    logic [DATA_W-1:0] ext_wdata_q, ext_wdata_d;
    logic [SEL_W-1:0]  ext_strb_q, ext_strb_d;
    logic              is_wr_q, is_wr_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        flags_q, flags_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  wdog_q, wdog_d;
    logic              err_inc;

    logic              req;
    logic              csr_hit;
    logic              win_hit;
    logic [DATA_W-1:0] csr_rdata;

    assign req     = bus.wbs_cyc_i & bus.wbs_stb_i;
    assign csr_hit = (bus.wbs_adr_i == CSR_ADDR);
    assign win_hit = ((bus.wbs_adr_i & ADDR_MASK) == BASE_ADDR);

    always_comb begin
        csr_rdata       = '0;
        csr_rdata[15:8] = err_cnt_q;
        csr_rdata[1:0]  = flags_q;
    end

    always_comb begin
        state_d     = state_q;
        ext_valid_d = ext_valid_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        ext_strb_d  = ext_strb_q;
        is_wr_d     = is_wr_q;
        ack_d       = 1'b0;
        rdata_d     = rdata_q;
        flags_d     = flags_q;
        err_cnt_d   = err_cnt_q;
        wdog_d      = wdog_q;
        err_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (csr_hit) begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                        if (bus.wbs_we_i) begin
                            rdata_d = '0;
                            if (bus.wbs_sel_i[0]) begin
                                if (bus.wbs_dat_i[0]) flags_d[0] = 1'b0;
                                if (bus.wbs_dat_i[1]) flags_d[1] = 1'b0;
                                if (bus.wbs_dat_i[2]) err_cnt_d  = '0;
                            end
                        end else begin
                            rdata_d = csr_rdata;
                        end
                    end else if (win_hit) begin
                        state_d     = EXT;
                        ext_valid_d = 1'b1;
                        ext_addr_d  = bus.wbs_adr_i & ~ADDR_MASK;
                        ext_wdata_d = bus.wbs_dat_i;
                        ext_strb_d  = bus.wbs_we_i ? bus.wbs_sel_i : '0;
                        is_wr_d     = bus.wbs_we_i;
                        wdog_d      = '0;
                    end else begin
                        // Miss: no ext activity, write data is dropped.
                        state_d    = ACK;
                        ack_d      = 1'b1;
                        rdata_d    = ERR_DATA;
                        flags_d[0] = 1'b1;
                        err_inc    = 1'b1;
                    end
                end
            end
            EXT: begin
                // ext_ready beats a watchdog expiry landing in the same cycle.
                if (bus.ext_ready) begin
                    state_d     = ACK;
                    ack_d       = 1'b1;
                    ext_valid_d = 1'b0;
                    rdata_d     = is_wr_q ? '0 : bus.ext_read_data;
                end else if (WDOG_EN && (wdog_q == TO_VAL)) begin
                    state_d     = ACK;
                    ack_d       = 1'b1;
                    ext_valid_d = 1'b0;
                    rdata_d     = ERR_DATA;
                    flags_d[1]  = 1'b1;
                    err_inc     = 1'b1;
                end else begin
                    wdog_d = wdog_q + CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            ext_valid_q <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            ext_strb_q  <= '0;
            is_wr_q     <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            flags_q     <= '0;
            err_cnt_q   <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            ext_valid_q <= ext_valid_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            ext_strb_q  <= ext_strb_d;
            is_wr_q     <= is_wr_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            flags_q     <= flags_d;
            err_cnt_q   <= err_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    assign bus.wbs_ack_o        = ack_q;
    assign bus.wbs_dat_o        = rdata_q;
    assign bus.ext_valid        = ext_valid_q;
    assign bus.ext_address      = ext_addr_q;
    assign bus.ext_write_data   = ext_wdata_q;
    assign bus.ext_write_strobe = ext_strb_q;
    assign err_irq              = flags_q[0] | flags_q[1];
endmodule

// File: tb/tb_wb_ext_bridge.sv
// Bench for wb_ext_bridge: dut0 uses default parameters, dut1 uses a 4-cycle watchdog.
// dsel steers the shared Wishbone stimulus to one DUT; results go through a queue scoreboard.
module tb_wb_ext_bridge;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
    localparam logic [31:0] CSR  = 32'h2FFF_FF00;
    localparam logic [31:0] MASK = 32'hFFF0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        dsel;
    logic        cyc, stb, we, rdy;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, rdata;

    logic        ack, vld, irq, irq0, irq1;
    logic [31:0] dat_o, ext_addr, ext_wd;
    logic [3:0]  strb;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    wb_ext_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    wb_ext_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    assign bus0.wbs_cyc_i     = cyc & ~dsel;
    assign bus1.wbs_cyc_i     = cyc & dsel;
    assign bus0.wbs_stb_i     = stb;
    assign bus1.wbs_stb_i     = stb;
    assign bus0.wbs_we_i      = we;
    assign bus1.wbs_we_i      = we;
    assign bus0.wbs_sel_i     = sel;
    assign bus1.wbs_sel_i     = sel;
    assign bus0.wbs_adr_i     = adr;
    assign bus1.wbs_adr_i     = adr;
    assign bus0.wbs_dat_i     = wdat;
    assign bus1.wbs_dat_i     = wdat;
    assign bus0.ext_ready     = rdy;
    assign bus1.ext_ready     = rdy;
    assign bus0.ext_read_data = rdata;
    assign bus1.ext_read_data = rdata;

    assign ack      = dsel ? bus1.wbs_ack_o        : bus0.wbs_ack_o;
    assign dat_o    = dsel ? bus1.wbs_dat_o        : bus0.wbs_dat_o;
    assign vld      = dsel ? bus1.ext_valid        : bus0.ext_valid;
    assign ext_addr = dsel ? bus1.ext_address      : bus0.ext_address;
    assign ext_wd   = dsel ? bus1.ext_write_data   : bus0.ext_write_data;
    assign strb     = dsel ? bus1.ext_write_strobe : bus0.ext_write_strobe;
    assign irq      = dsel ? irq1 : irq0;

    wb_ext_bridge u_dut0 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus0),
        .err_irq  (irq0)
    );

    wb_ext_bridge #(.TIMEOUT(4)) u_dut1 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus1),
        .err_irq  (irq1)
    );

    // One Wishbone transaction; dly<0 means ext_ready never comes.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int dly, input logic [31:0] rd,
                           input int exp_lat, input logic [31:0] exp_dat, input bit chk_dat,
                           input int exp_vcyc, input string nm);
        int lat, vcyc, bad, e_lat;
        bit done;
        logic [31:0] e_dat;
        exp_q.push_back(exp_dat);
        lat_q.push_back(exp_lat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s; rdy = 1'b0; rdata = rd;
        @(posedge clk);
        lat = 0; vcyc = 0; bad = 0; done = 1'b0;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
            if (vld === 1'b1) begin
                vcyc++;
                if (ext_addr !== (a & ~MASK) || strb !== (w ? s : 4'h0) || ext_wd !== d) bad++;
            end
            rdy = (dly >= 0) && (lat - 1 == dly);
            if (ack === 1'b1) done = 1'b1;
        end
        rdy = 1'b0;
        e_dat = exp_q.pop_front();
        e_lat = lat_q.pop_front();
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s ack: missing after %0d cycles", nm, lat);
        end else begin
            checks++;
            if (lat != e_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", nm, lat, e_lat);
            end
            if (chk_dat) begin
                checks++;
                if (dat_o !== e_dat) begin
                    errors++;
                    $display("FAIL %s data: got %h expected %h", nm, dat_o, e_dat);
                end
            end
        end
        checks++;
        if (vcyc != exp_vcyc) begin
            errors++;
            $display("FAIL %s ext_valid cycles: got %0d expected %0d", nm, vcyc, exp_vcyc);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s ext fields: %0d bad cycles expected 0", nm, bad);
        end
        // Strobe stays up through the ACK cycle; the bridge must not take it again.
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL %s ack pulse: got %b expected 0", nm, ack);
        end
    endtask

    task automatic chk_irq(input logic e, input string nm);
        checks++;
        if (irq !== e) begin
            errors++;
            $display("FAIL %s err_irq: got %b expected %b", nm, irq, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; dsel = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = '0; adr = '0; wdat = '0; rdy = 1'b0; rdata = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            dsel = k[0];
            @(negedge clk);
            checks++;
            if ({ack, vld, irq, strb, dat_o, ext_addr, ext_wd} !== '0) begin
                errors++;
                $display("FAIL reset dut%0d: got ack=%b vld=%b irq=%b strb=%h dat=%h addr=%h wd=%h expected all 0",
                         k, ack, vld, irq, strb, dat_o, ext_addr, ext_wd);
            end
        end
        dsel = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        run_txn(1'b0, CSR, 0, 4'h0, 0, 0, 1, 32'h0, 1'b1, 0, "reset_csr");
    endtask

    task automatic test_window_rw();
        run_txn(1'b1, 32'h3000_0010, 32'hA5A5_0001, 4'hF, 0, 0, 2, 32'h0, 1'b1, 1, "win_write");
        run_txn(1'b0, 32'h3000_0010, 0, 4'h0, 0, 32'h1234_5678, 2, 32'h1234_5678, 1'b1, 1, "win_read");
    endtask

    task automatic test_wait_states();
        run_txn(1'b0, 32'h3000_0100, 0, 4'h0, 5, 32'h0BAD_F00D, 7, 32'h0BAD_F00D, 1'b1, 6, "wait5");
        chk_irq(1'b0, "wait5");
        run_txn(1'b0, CSR, 0, 4'h0, 0, 0, 1, 32'h0, 1'b1, 0, "wait5_csr");
    endtask

    task automatic test_decode_miss();
        run_txn(1'b0, 32'h1000_0000, 0, 4'h0, 0, 0, 1, ERR, 1'b1, 0, "miss_read");
        chk_irq(1'b1, "miss_read");
        run_txn(1'b0, CSR, 0, 4'h0, 0, 0, 1, 32'h0000_0101, 1'b1, 0, "miss_csr1");
        run_txn(1'b1, 32'h4000_0000, 32'h1111_2222, 4'hF, 0, 0, 1, ERR, 1'b1, 0, "miss_write");
        run_txn(1'b0, CSR, 0, 4'h0, 0, 0, 1, 32'h0000_0201, 1'b1, 0, "miss_csr2");
        run_txn(1'b1, CSR, 32'h7, 4'h1, 0, 0, 1, 32'h0, 1'b0, 0, "miss_clear");
        chk_irq(1'b0, "miss_clear");
        run_txn(1'b0, CSR, 0, 4'h0, 0, 0, 1, 32'h0, 1'b1, 0, "miss_csr3");
    endtask

    task automatic test_reset_in_ext();
        int acks;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0040; sel = 4'h0; rdy = 1'b0;
        @(posedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (vld !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_ext outputs: got vld=%b ack=%b expected 0 0", vld, ack);
        end
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack === 1'b1 || vld === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL rst_ext quiet: got %0d active cycles expected 0", acks);
        end
        run_txn(1'b0, 32'h3000_0044, 0, 4'h0, 1, 32'h5555_AAAA, 3, 32'h5555_AAAA, 1'b1, 2, "rst_ext_after");
    endtask

    task automatic test_timeout();
        dsel = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 32'h3000_0080, 0, 4'h0, -1, 0, 6, ERR, 1'b1, 5, "timeout");
        chk_irq(1'b1, "timeout");
        run_txn(1'b0, CSR, 0, 4'h0, 0, 0, 1, 32'h0000_0102, 1'b1, 0, "timeout_csr");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            run_txn(i[0], 32'h3000_0000 + 32'(i * 4), 32'(i), 4'hF, -1, 0, 6, ERR, 1'b1, 5, "sat");
        end
        run_txn(1'b0, CSR, 0, 4'h0, 0, 0, 1, 32'h0000_FF02, 1'b1, 0, "sat_csr");
        run_txn(1'b1, CSR, 32'h7, 4'h1, 0, 0, 1, 32'h0, 1'b0, 0, "sat_clear");
        chk_irq(1'b0, "sat_clear");
        run_txn(1'b0, CSR, 0, 4'h0, 0, 0, 1, 32'h0, 1'b1, 0, "sat_csr_clr");
    endtask

    task automatic test_race();
        run_txn(1'b0, 32'h3000_0200, 0, 4'h0, 4, 32'hCAFE_F00D, 6, 32'hCAFE_F00D, 1'b1, 5, "race");
        chk_irq(1'b0, "race");
        run_txn(1'b0, CSR, 0, 4'h0, 0, 0, 1, 32'h0, 1'b1, 0, "race_csr");
    endtask

    task automatic test_back_to_back();
        int dly;
        logic w;
        logic [31:0] rd, wd;
        dsel = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            dly = $urandom_range(0, 3);
            w   = i[0];
            rd  = $urandom;
            wd  = $urandom;
            run_txn(w, 32'h3000_0000 + 32'($urandom_range(0, 1023) * 4), wd, 4'(i + 1), dly, rd,
                    2 + dly, w ? 32'h0 : rd, 1'b1, dly + 1, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_window_rw();
        test_wait_states();
        test_decode_miss();
        test_reset_in_ext();
        test_timeout();
        test_saturation();
        test_race();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
